// File: rtl/pdp11_pkg.sv
// Shared PDP-11 datapath definitions: word widths, the ASH/ASHC sequencer
// state encoding and the condition-code bit order (N, Z, V, C).
package pdp11_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned DWORD_W = 32;
    localparam int unsigned CNT_W   = 6;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_e;

    // Condition codes, MSB first: N, Z, V, C
    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } cc_t;

endpackage

// File: rtl/ash_seq_if.sv
// Handshake between ash_seq and the 32-bit serial shifter.
//   master (sequencer): drives sh_ready, sh_in, sh_shift
//   slave  (shifter)  : drives sh_done, sh_out, sh_last_bit
interface ash_seq_if;
    import pdp11_pkg::*;

    logic               sh_ready;
    logic [DWORD_W-1:0] sh_in;
    logic [CNT_W-1:0]   sh_shift;
    logic               sh_done;
    logic [DWORD_W-1:0] sh_out;
    logic               sh_last_bit;

    modport master (
        output sh_ready, sh_in, sh_shift,
        input  sh_done, sh_out, sh_last_bit
    );

    modport slave (
        input  sh_ready, sh_in, sh_shift,
        output sh_done, sh_out, sh_last_bit
    );

endinterface

// File: rtl/ash_ovf.sv
// Overflow (V) for an arithmetic left shift: set when the sign bit would
// change at any step of the shift.
//   i_opnd : operand, left-justified (16-bit operands sit in [31:16], low half 0)
//   i_wide : 1 = 32-bit operand, 0 = 16-bit operand
//   i_cnt  : two's-complement count, positive = left
//   o_v_c  : overflow flag (combinational)
module ash_ovf
    import pdp11_pkg::*;
(
    input  logic [DWORD_W-1:0] i_opnd,
    input  logic               i_wide,
    input  logic [CNT_W-1:0]   i_cnt,
    output logic               o_v_c
);

    logic [CNT_W-1:0]   w_width;
    logic [CNT_W-1:0]   w_cnt_p1;
    logic [CNT_W-1:0]   w_span;
    logic [DWORD_W-1:0] w_mask;
    logic [DWORD_W-1:0] w_top;

    // Top min(n+1, w) bits must all match the sign, and any nonzero operand
    // shifted by the full width or more passes a 1 through the sign position.
    always_comb begin
        w_width  = i_wide ? CNT_W'(DWORD_W) : CNT_W'(WORD_W);
        w_cnt_p1 = CNT_W'(i_cnt + CNT_W'(1));
        w_span   = (w_cnt_p1 < w_width) ? w_cnt_p1 : w_width;
        w_mask   = ~(32'hFFFF_FFFF >> w_span);
        w_top    = i_opnd & w_mask;
        o_v_c    = 1'b0;
        if (!i_cnt[CNT_W-1] && (i_cnt != '0)) begin
            if ((w_top != '0) && (w_top != w_mask)) begin
                o_v_c = 1'b1;
            end
            if ((i_cnt >= w_width) && (i_opnd != '0)) begin
                o_v_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ash_seq.sv
// ASH / ASHC sequencer in front of the serial shifter.
// Accepts one request at a time, issues it to the shifter (or bypasses it for
// a zero count), and returns a one-cycle result pulse with N/Z/V/C.
//   clk, reset           : clock, async active-low reset
//   req_*                : request from execute (valid/ready, opcode, R, R|1, src)
//   resp_*               : registered result and condition codes
//   sh (ash_seq_if.master): shifter handshake
module ash_seq
    import pdp11_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_ashc,
    input  logic [WORD_W-1:0] req_hi,
    input  logic [WORD_W-1:0] req_lo,
    input  logic [WORD_W-1:0] req_src,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_hi,
    output logic [WORD_W-1:0] resp_lo,
    output logic              resp_n,
    output logic              resp_z,
    output logic              resp_v,
    output logic              resp_c,
    ash_seq_if.master         sh
);

    seq_state_e         r_state;
    seq_state_e         w_state_nxt;

    logic               r_req_ready;
    logic               r_resp_valid;
    logic [WORD_W-1:0]  r_resp_hi;
    logic [WORD_W-1:0]  r_resp_lo;
    cc_t                r_cc;
    logic               r_sh_ready;
    logic [DWORD_W-1:0] r_sh_in;
    logic [CNT_W-1:0]   r_sh_shift;
    logic               r_ashc;
    logic [WORD_W-1:0]  r_lo;
    logic               r_v;

    logic [CNT_W-1:0]   w_cnt;
    logic               w_src_unused;
    logic [DWORD_W-1:0] w_sh_in_nxt;
    logic [DWORD_W-1:0] w_ovf_opnd;
    logic               w_v_c;
    logic               w_accept;
    logic               w_load_resp;
    logic [WORD_W-1:0]  w_res_hi;
    logic [WORD_W-1:0]  w_res_lo;
    logic               w_res_wide;
    logic               w_res_v;
    logic               w_res_c;
    cc_t                w_cc;

    assign w_cnt        = req_src[CNT_W-1:0];
    assign w_src_unused = ^req_src[WORD_W-1:CNT_W];

    // Operand placement: ASH right shifts sign-extend into the low half so the
    // result lands in [15:0]; ASH left shifts work in the high half.
    always_comb begin
        if (req_ashc) begin
            w_sh_in_nxt = {req_hi, req_lo};
        end else if (w_cnt[CNT_W-1]) begin
            w_sh_in_nxt = {{WORD_W{req_hi[WORD_W-1]}}, req_hi};
        end else begin
            w_sh_in_nxt = {req_hi, 16'h0000};
        end
    end

    assign w_ovf_opnd = req_ashc ? {req_hi, req_lo} : {req_hi, 16'h0000};

    ash_ovf u_ovf (
        .i_opnd (w_ovf_opnd),
        .i_wide (req_ashc),
        .i_cnt  (w_cnt),
        .o_v_c  (w_v_c)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and result selection
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load_resp = 1'b0;
        w_res_hi    = '0;
        w_res_lo    = '0;
        w_res_wide  = 1'b0;
        w_res_v     = 1'b0;
        w_res_c     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_cnt == '0) begin
                        // Zero count bypasses the shifter: result is the operand
                        w_state_nxt = ST_RESP;
                        w_load_resp = 1'b1;
                        w_res_hi    = req_hi;
                        w_res_lo    = req_lo;
                        w_res_wide  = req_ashc;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (sh.sh_done) begin
                    w_state_nxt = ST_RESP;
                    w_load_resp = 1'b1;
                    w_res_wide  = r_ashc;
                    w_res_v     = r_v;
                    w_res_c     = sh.sh_last_bit;
                    if (r_ashc) begin
                        w_res_hi = sh.sh_out[31:16];
                        w_res_lo = sh.sh_out[15:0];
                    end else begin
                        w_res_hi = r_sh_shift[CNT_W-1] ? sh.sh_out[15:0] : sh.sh_out[31:16];
                        w_res_lo = r_lo;
                    end
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Result sign sits in bit 15 of the high word for both widths
    always_comb begin
        w_cc.n = w_res_hi[WORD_W-1];
        w_cc.z = w_res_wide ? ({w_res_hi, w_res_lo} == '0) : (w_res_hi == '0);
        w_cc.v = w_res_v;
        w_cc.c = w_res_c;
    end

    // Registered outputs and captured request fields
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_hi    <= '0;
            r_resp_lo    <= '0;
            r_cc         <= '0;
            r_sh_ready   <= 1'b0;
            r_sh_in      <= '0;
            r_sh_shift   <= '0;
            r_ashc       <= 1'b0;
            r_lo         <= '0;
            r_v          <= 1'b0;
        end else begin
            r_req_ready  <= (w_state_nxt == ST_IDLE);
            r_sh_ready   <= (w_state_nxt == ST_ISSUE);
            r_resp_valid <= w_load_resp;
            if (w_accept) begin
                r_ashc     <= req_ashc;
                r_lo       <= req_lo;
                r_sh_in    <= w_sh_in_nxt;
                r_sh_shift <= w_cnt;
                r_v        <= w_v_c;
            end
            if (w_load_resp) begin
                r_resp_hi <= w_res_hi;
                r_resp_lo <= w_res_lo;
                r_cc      <= w_cc;
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_hi     = r_resp_hi;
    assign resp_lo     = r_resp_lo;
    assign resp_n      = r_cc.n;
    assign resp_z      = r_cc.z;
    assign resp_v      = r_cc.v;
    assign resp_c      = r_cc.c;
    assign sh.sh_ready = r_sh_ready;
    assign sh.sh_in    = r_sh_in;
    assign sh.sh_shift = r_sh_shift;

endmodule

// File: tb/tb_ash_seq.sv
// Bench for ash_seq: behavioural serial shifter plus an arithmetic reference
// model of ASH/ASHC results, flags and latency.
module tb_ash_seq;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_ashc;
    logic [15:0] req_hi;
    logic [15:0] req_lo;
    logic [15:0] req_src;
    logic        resp_valid;
    logic [15:0] resp_hi;
    logic [15:0] resp_lo;
    logic        resp_n;
    logic        resp_z;
    logic        resp_v;
    logic        resp_c;

    int total = 0;
    int bad   = 0;

    ash_seq_if sh_if ();

    ash_seq u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ashc   (req_ashc),
        .req_hi     (req_hi),
        .req_lo     (req_lo),
        .req_src    (req_src),
        .resp_valid (resp_valid),
        .resp_hi    (resp_hi),
        .resp_lo    (resp_lo),
        .resp_n     (resp_n),
        .resp_z     (resp_z),
        .resp_v     (resp_v),
        .resp_c     (resp_c),
        .sh         (sh_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial shifter: loads on sh_ready, one step per clock, done held until
    // sh_ready drops. Synchronous reset from ~reset.
    logic       m_busy;
    logic [6:0] m_rem;
    logic       m_left;

    always @(posedge clk) begin
        if (!reset) begin
            m_busy            <= 1'b0;
            m_rem             <= '0;
            m_left            <= 1'b0;
            sh_if.sh_done     <= 1'b0;
            sh_if.sh_out      <= '0;
            sh_if.sh_last_bit <= 1'b0;
        end else if (!m_busy) begin
            if (sh_if.sh_ready) begin
                m_busy        <= 1'b1;
                sh_if.sh_out  <= sh_if.sh_in;
                m_left        <= !sh_if.sh_shift[5];
                m_rem         <= sh_if.sh_shift[5] ? 7'(7'd64 - {1'b0, sh_if.sh_shift})
                                                   : {1'b0, sh_if.sh_shift};
                sh_if.sh_done <= 1'b0;
            end
        end else if (!sh_if.sh_done) begin
            if (m_rem != '0) begin
                if (m_left) begin
                    sh_if.sh_last_bit <= sh_if.sh_out[31];
                    sh_if.sh_out      <= {sh_if.sh_out[30:0], 1'b0};
                end else begin
                    sh_if.sh_last_bit <= sh_if.sh_out[0];
                    sh_if.sh_out      <= {sh_if.sh_out[31], sh_if.sh_out[31:1]};
                end
                m_rem <= 7'(m_rem - 7'd1);
                if (m_rem == 7'd1) sh_if.sh_done <= 1'b1;
            end else begin
                sh_if.sh_done <= 1'b1;
            end
        end else if (!sh_if.sh_ready) begin
            m_busy        <= 1'b0;
            sh_if.sh_done <= 1'b0;
        end
    end

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic [3:0]  cc;
        int          steps;
    } exp_t;

    // Reference: plain arithmetic shift, V by watching the sign step by step
    function automatic exp_t ref_model(input logic ashc, input logic [15:0] hi,
                                       input logic [15:0] lo, input logic [15:0] src);
        exp_t   e;
        int     cnt;
        int     w;
        int     m;
        longint val;
        longint mask;
        longint res;
        longint sv;
        longint t0;
        longint t1;
        logic   v;
        logic   c;
        cnt = int'(src[5:0]);
        if (cnt >= 32) cnt = cnt - 64;
        w    = ashc ? 32 : 16;
        val  = ashc ? longint'({hi, lo}) : longint'(hi);
        mask = (longint'(1) << w) - 1;
        res  = val;
        v    = 1'b0;
        c    = 1'b0;
        if (cnt > 0) begin
            res = (val << cnt) & mask;
            if (cnt <= w) begin
                t0 = val >> (w - cnt);
                c  = t0[0];
            end
            for (int k = 1; k <= cnt; k++) begin
                t0 = (val << (k - 1)) >> (w - 1);
                t1 = (val << k) >> (w - 1);
                if (t0[0] != t1[0]) v = 1'b1;
            end
        end else if (cnt < 0) begin
            m  = -cnt;
            t0 = val >> (w - 1);
            sv = t0[0] ? (val | ~mask) : val;
            res = (sv >>> m) & mask;
            t1 = sv >> (m - 1);
            c  = t1[0];
        end
        e.hi    = ashc ? res[31:16] : res[15:0];
        e.lo    = ashc ? res[15:0] : lo;
        t0      = res >> (w - 1);
        e.cc    = {t0[0], (res == 0), v, c};
        e.steps = (cnt < 0) ? -cnt : cnt;
        return e;
    endfunction

    // Issue one request from a negedge with the DUT idle; observe until
    // req_ready returns. Cycle 0 is the acceptance cycle.
    task automatic run_req(input logic ashc, input logic [15:0] hi, input logic [15:0] lo,
                           input logic [15:0] src, output logic [15:0] o_hi,
                           output logic [15:0] o_lo, output logic [3:0] o_cc,
                           output int rcyc, output int rdy_cyc, output int shr_first,
                           output int shr_cnt);
        o_hi      = 'x;
        o_lo      = 'x;
        o_cc      = 'x;
        rcyc      = -1;
        rdy_cyc   = -1;
        shr_first = -1;
        shr_cnt   = 0;
        req_valid = 1'b1;
        req_ashc  = ashc;
        req_hi    = hi;
        req_lo    = lo;
        req_src   = src;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_hi    = 16'($urandom);
        req_lo    = 16'($urandom);
        req_src   = 16'($urandom);
        req_ashc  = 1'($urandom);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (sh_if.sh_ready) begin
                if (shr_first < 0) shr_first = c;
                shr_cnt++;
            end
            if (resp_valid && rcyc < 0) begin
                rcyc = c;
                o_hi = resp_hi;
                o_lo = resp_lo;
                o_cc = {resp_n, resp_z, resp_v, resp_c};
            end
            if (req_ready) begin
                rdy_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        total++; if ({resp_hi, resp_lo} !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", {resp_hi, resp_lo}); end
        total++; if ({resp_n, resp_z, resp_v, resp_c} !== 4'h0) begin bad++; $display("FAIL reset_cc got=%b exp=0000", {resp_n, resp_z, resp_v, resp_c}); end
        total++; if (sh_if.sh_ready !== 1'b0) begin bad++; $display("FAIL reset_sh_ready got=%b exp=0", sh_if.sh_ready); end
        total++; if (sh_if.sh_in !== 32'h0) begin bad++; $display("FAIL reset_sh_in got=%h exp=0", sh_if.sh_in); end
        total++; if (sh_if.sh_shift !== 6'h0) begin bad++; $display("FAIL reset_sh_shift got=%h exp=0", sh_if.sh_shift); end
    endtask

    typedef struct {
        logic        ashc;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [15:0] src;
        logic [15:0] e_hi;
        logic [15:0] e_lo;
        logic [3:0]  e_cc;
        int          e_n;
    } dvec_t;

    task automatic test_directed();
        dvec_t       tbl[8];
        logic [15:0] g_hi;
        logic [15:0] g_lo;
        logic [3:0]  g_cc;
        int          rc;
        int          rd;
        int          sf;
        int          sc;
        tbl[0] = '{1'b0, 16'h0001, 16'h1234, 16'h0003, 16'h0008, 16'h1234, 4'b0000, 3};
        tbl[1] = '{1'b0, 16'h4000, 16'h0000, 16'h0001, 16'h8000, 16'h0000, 4'b1010, 1};
        tbl[2] = '{1'b0, 16'h8001, 16'h5A5A, 16'h003F, 16'hC000, 16'h5A5A, 4'b1001, 1};
        tbl[3] = '{1'b1, 16'h0000, 16'h8000, 16'h0001, 16'h0001, 16'h0000, 4'b0000, 1};
        tbl[4] = '{1'b1, 16'h8000, 16'h0000, 16'h0020, 16'hFFFF, 16'hFFFF, 4'b1001, 32};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 16'hFFC0, 16'h0000, 16'h0000, 4'b0100, 0};
        tbl[6] = '{1'b0, 16'h0001, 16'hBEEF, 16'h0010, 16'h0000, 16'hBEEF, 4'b0111, 16};
        tbl[7] = '{1'b1, 16'h2000, 16'h0000, 16'h0002, 16'h8000, 16'h0000, 4'b1010, 2};
        for (int i = 0; i < 8; i++) begin
            run_req(tbl[i].ashc, tbl[i].hi, tbl[i].lo, tbl[i].src, g_hi, g_lo, g_cc, rc, rd, sf, sc);
            total++; if (g_hi !== tbl[i].e_hi) begin bad++; $display("FAIL dir%0d_hi got=%h exp=%h", i, g_hi, tbl[i].e_hi); end
            total++; if (g_lo !== tbl[i].e_lo) begin bad++; $display("FAIL dir%0d_lo got=%h exp=%h", i, g_lo, tbl[i].e_lo); end
            total++; if (g_cc !== tbl[i].e_cc) begin bad++; $display("FAIL dir%0d_nzvc got=%b exp=%b", i, g_cc, tbl[i].e_cc); end
            total++; if (rc !== ((tbl[i].e_n == 0) ? 1 : tbl[i].e_n + 3)) begin bad++; $display("FAIL dir%0d_resp_cycle got=%0d exp=%0d", i, rc, (tbl[i].e_n == 0) ? 1 : tbl[i].e_n + 3); end
            total++; if (rd !== ((tbl[i].e_n == 0) ? 2 : tbl[i].e_n + 4)) begin bad++; $display("FAIL dir%0d_ready_cycle got=%0d exp=%0d", i, rd, (tbl[i].e_n == 0) ? 2 : tbl[i].e_n + 4); end
            total++; if (sc !== ((tbl[i].e_n == 0) ? 0 : tbl[i].e_n + 2)) begin bad++; $display("FAIL dir%0d_sh_ready_cycles got=%0d exp=%0d", i, sc, (tbl[i].e_n == 0) ? 0 : tbl[i].e_n + 2); end
            total++; if (sf !== ((tbl[i].e_n == 0) ? -1 : 1)) begin bad++; $display("FAIL dir%0d_sh_ready_first got=%0d exp=%0d", i, sf, (tbl[i].e_n == 0) ? -1 : 1); end
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic        ashc;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [15:0] src;
        logic [15:0] g_hi;
        logic [15:0] g_lo;
        logic [3:0]  g_cc;
        int          rc;
        int          rd;
        int          sf;
        int          sc;
        for (int i = 0; i < 30; i++) begin
            ashc = 1'($urandom);
            hi   = 16'($urandom);
            lo   = 16'($urandom);
            src  = 16'($urandom);
            if ($urandom_range(0, 5) == 0) src[5:0] = 6'h00;
            if ($urandom_range(0, 3) == 0) hi = {16{hi[0]}};
            e = ref_model(ashc, hi, lo, src);
            run_req(ashc, hi, lo, src, g_hi, g_lo, g_cc, rc, rd, sf, sc);
            total++; if ({g_hi, g_lo} !== {e.hi, e.lo}) begin bad++; $display("FAIL rnd%0d_result ashc=%b in=%h_%h src=%h got=%h exp=%h", i, ashc, hi, lo, src, {g_hi, g_lo}, {e.hi, e.lo}); end
            total++; if (g_cc !== e.cc) begin bad++; $display("FAIL rnd%0d_nzvc ashc=%b in=%h_%h src=%h got=%b exp=%b", i, ashc, hi, lo, src, g_cc, e.cc); end
            total++; if (rc !== ((e.steps == 0) ? 1 : e.steps + 3)) begin bad++; $display("FAIL rnd%0d_resp_cycle got=%0d exp=%0d", i, rc, (e.steps == 0) ? 1 : e.steps + 3); end
            total++; if (sc !== ((e.steps == 0) ? 0 : e.steps + 2)) begin bad++; $display("FAIL rnd%0d_sh_ready_cycles got=%0d exp=%0d", i, sc, (e.steps == 0) ? 0 : e.steps + 2); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        q[$];
        exp_t        e;
        logic        b_ashc[4];
        logic [15:0] b_hi[4];
        logic [15:0] b_lo[4];
        logic [15:0] b_src[4];
        int          idx;
        int          nresp;
        logic        acc;
        for (int i = 0; i < 4; i++) begin
            b_ashc[i] = 1'($urandom);
            b_hi[i]   = 16'($urandom);
            b_lo[i]   = 16'($urandom);
            b_src[i]  = {10'h0, 6'($urandom_range(0, 12))};
        end
        b_src[1] = 16'h0000;
        b_src[2] = 16'h003E;
        idx   = 0;
        nresp = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_ashc  = b_ashc[0];
        req_hi    = b_hi[0];
        req_lo    = b_lo[0];
        req_src   = b_src[0];
        for (int c = 0; c < 400 && nresp < 4; c++) begin
            if (resp_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_unexpected_resp cycle=%0d got=%h exp=none", c, {resp_hi, resp_lo});
                end else begin
                    e = q.pop_front();
                    if ({resp_hi, resp_lo, resp_n, resp_z, resp_v, resp_c} !== {e.hi, e.lo, e.cc}) begin
                        bad++;
                        $display("FAIL b2b_resp%0d got=%h/%b exp=%h/%b", nresp, {resp_hi, resp_lo},
                                 {resp_n, resp_z, resp_v, resp_c}, {e.hi, e.lo}, e.cc);
                    end
                    nresp++;
                end
            end
            acc = req_valid && req_ready;
            if (acc) q.push_back(ref_model(b_ashc[idx], b_hi[idx], b_lo[idx], b_src[idx]));
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    req_ashc = b_ashc[idx];
                    req_hi   = b_hi[idx];
                    req_lo   = b_lo[idx];
                    req_src  = b_src[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        total++; if (nresp !== 4) begin bad++; $display("FAIL b2b_resp_count got=%0d exp=4", nresp); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        logic [15:0] g_hi;
        logic [15:0] g_lo;
        logic [3:0]  g_cc;
        int          rc;
        int          rd;
        int          sf;
        int          sc;
        int          pulses;
        req_valid = 1'b1;
        req_ashc  = 1'b0;
        req_hi    = 16'h1234;
        req_lo    = 16'h0000;
        req_src   = 16'h0014;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (sh_if.sh_ready !== 1'b1) begin bad++; $display("FAIL mid_issue_sh_ready got=%b exp=1", sh_if.sh_ready); end
        reset = 1'b0;
        #1;
        total++; if (sh_if.sh_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_sh_ready got=%b exp=0", sh_if.sh_ready); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_req_ready got=%b exp=1", req_ready); end
        total++; if ({sh_if.sh_in, sh_if.sh_shift} !== 38'h0) begin bad++; $display("FAIL mid_rst_sh_bus got=%h exp=0", {sh_if.sh_in, sh_if.sh_shift}); end
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        reset = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (resp_valid || sh_if.sh_ready) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL mid_rst_no_activity got=%0d exp=0", pulses); end
        e = ref_model(1'b1, 16'h00F0, 16'h0F0F, 16'h003C);
        run_req(1'b1, 16'h00F0, 16'h0F0F, 16'h003C, g_hi, g_lo, g_cc, rc, rd, sf, sc);
        total++; if ({g_hi, g_lo} !== {e.hi, e.lo}) begin bad++; $display("FAIL mid_after_result got=%h exp=%h", {g_hi, g_lo}, {e.hi, e.lo}); end
        total++; if (g_cc !== e.cc) begin bad++; $display("FAIL mid_after_nzvc got=%b exp=%b", g_cc, e.cc); end
        total++; if (rc !== e.steps + 3) begin bad++; $display("FAIL mid_after_resp_cycle got=%0d exp=%0d", rc, e.steps + 3); end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_ashc  = 1'b0;
        req_hi    = '0;
        req_lo    = '0;
        req_src   = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ash_seq.md
# ash_seq

Sequencer for the PDP-11 ASH and ASHC instructions. It sits directly upstream of the 32-bit serial shifter `shift32`: it accepts an operand and count from the execute stage, drives the shifter's `ready`/`in`/`shift` handshake, and captures `out`/`last_bit` on `done`. It returns the 16- or 32-bit result with N, Z, V and C, and bypasses the shifter for a zero count.

## Interface
- No parameters.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; asserted when 0.
- `req_valid` in 1: request strobe, qualified by `req_ready`.
- `req_ready` out 1: high when in IDLE.
- `req_ashc` in 1: 1 = ASHC (32-bit {R,R|1}), 0 = ASH (16-bit R).
- `req_hi` in 16: R.
- `req_lo` in 16: R|1, used by ASHC only.
- `req_src` in 16: source operand; bits [5:0] are a two's-complement count, -32..+31. Positive shifts left.
- `resp_valid` out 1: one-cycle result pulse. There is no backpressure.
- `resp_hi`, `resp_lo` out 16 each: result words. For ASH, `resp_lo` is the captured `req_lo`, unchanged.
- `resp_n`, `resp_z`, `resp_v`, `resp_c` out 1 each: condition codes.
- `sh_ready` out 1: registered; high only in ISSUE.
- `sh_in` out 32: registered operand, held stable from acceptance until the next acceptance.
- `sh_shift` out 6: registered count.
- `sh_done` in 1, `sh_out` in 32, `sh_last_bit` in 1: shifter outputs.

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE → RESP on acceptance (`req_valid & req_ready`) when count == 0.
- IDLE → ISSUE on acceptance when count ≠ 0.
- ISSUE → RESP when `sh_done` = 1.
- RESP → IDLE always.
- On acceptance, register the count, the opcode, `req_lo`, `sh_in` and the V flag.
- Operand placement:
  - ASHC: `sh_in` = {hi, lo}.
  - ASH, left: `sh_in` = {hi, 16'h0}.
  - ASH, right: `sh_in` = {{16{hi[15]}}, hi}.
- Result selection:
  - ASHC: {`resp_hi`, `resp_lo`} = `sh_out`.
  - ASH, left: `resp_hi` = `sh_out[31:16]`.
  - ASH, right: `resp_hi` = `sh_out[15:0]`.
- C = `sh_last_bit`, captured in the `sh_done` cycle. C = 0 for count 0.
- N = result sign bit (bit 15 for ASH, bit 31 for ASHC). Z = result equals 0, over 16 or 32 bits.
- V: sign changed at any step. Computed at acceptance and applies to left shifts only.
  - Operand width w = 16 or 32, left count n.
  - V = 1 if the top min(n+1, w) operand bits are not all equal.
  - V = 1 if n ≥ w and the operand is nonzero.
  - V = 0 for right shifts and for count 0.
- Count 0: result = operand, C = 0, V = 0, N/Z from the operand. `sh_ready` never asserts.
- Reset mid-operation:
  - The block returns to IDLE, with all outputs 0 except `req_ready` = 1.
  - The integrator drives the shifter's active-high synchronous reset from `~reset`, so both blocks restart together.

## Timing
- Cycle 0: acceptance. Cycle 1: `sh_ready` = 1 with `sh_in`/`sh_shift` valid.
- For a shift of n steps (n = count for left, |count| for right), `sh_done` rises in cycle n+2.
- RESP runs in cycle n+3, and `resp_valid` is high there. `sh_ready` is already 0 in that cycle, so the shifter returns to idle at the end of n+3.
- `req_ready` rises again in cycle n+4.
- Count 0: `resp_valid` in cycle 1, `req_ready` in cycle 2.
- Result and flag outputs are registered and hold their value until the next RESP.
- Reset values: `req_ready` = 1. `resp_*`, `sh_ready`, `sh_in` and `sh_shift` = 0.

## Structure
- Shared package `pdp11_pkg`: state encoding constants and the condition-code bit order (N, Z, V, C).
- The V computation is a natural sub-module `ash_ovf` (combinational): operand, width select and count in; V out.
- The shifter is instantiated by the parent, not inside `ash_seq`.

## Test plan
- ASH hi=0x0001, src[5:0]=3 → `resp_hi`=0x0008, NZVC=0000, `resp_valid` in cycle 6, `sh_ready` high in cycles 1–5.
- ASH hi=0x4000, count 1 → 0x8000, N=1 V=1 C=0. Separately, ASH hi=0x8001, count 6'h3F → 0xC000, N=1 V=0 C=1.
- ASHC {0x0000,0x8000}, count 1 → {0x0001,0x0000}, NZVC=0000.
- ASHC {0x8000,0x0000}, count 6'h20 (-32) → {0xFFFF,0xFFFF}, N=1 C=1 V=0, `resp_valid` in cycle 35.
- Count 0 with hi=0x0000 → `resp_valid` in cycle 1, Z=1, C=0, `sh_ready` never asserted. Back-to-back requests are each accepted only when `req_ready`=1.
- Reset=0 in the middle of ISSUE → IDLE, `sh_ready`=0, `resp_valid` not pulsed; the next request completes correctly.
